// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: qualifies a synchronised PLL lock, holds every channel in reset,
// then releases the channels in index order at a fixed spacing. Supports lock-loss abort and software re-sequencing.
module reset_sequencer #(
    parameter int unsigned        CH_NUM    = 4,
    parameter int unsigned        CNT_W     = 8,
    parameter int unsigned        LOCK_FILT = 16,
    parameter int unsigned        HOLD_NUM  = 10,
    parameter int unsigned        STEP_NUM  = 4,
    parameter logic [CH_NUM-1:0]  RST_TYPE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              sw_rst_req,
    output logic [CH_NUM-1:0] rst_out,
    output logic              rst_done
);

    localparam int unsigned       IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam longint unsigned   CNT_MAX   = (64'd1 << CNT_W) - 64'd1;
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_NUM - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_NUM - 1);
    localparam logic [IDX_W-1:0]  LAST_CH   = IDX_W'(CH_NUM - 1);

    if (CH_NUM < 1 || CNT_W < 1 ||
        LOCK_FILT < 1 || LOCK_FILT > CNT_MAX ||
        HOLD_NUM  < 1 || HOLD_NUM  > CNT_MAX ||
        STEP_NUM  < 1 || STEP_NUM  > CNT_MAX) begin : g_bad_param
        $error("reset_sequencer: parameter outside its legal range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_sync1, r_lock_s;
    logic [CNT_W-1:0]    r_lock_cnt, w_lock_cnt_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]    r_ch_idx, w_ch_idx_nxt;
    logic [CH_NUM-1:0]   r_rst_out, w_rst_out_nxt;
    logic                r_done, w_done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_lock_s   <= 1'b0;
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            r_cnt      <= '0;
            r_ch_idx   <= '0;
            r_rst_out  <= RST_TYPE;
            r_done     <= 1'b0;
        end else begin
            r_sync1    <= locked;
            r_lock_s   <= r_sync1;
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ch_idx   <= w_ch_idx_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        w_cnt_nxt      = r_cnt;
        w_ch_idx_nxt   = r_ch_idx;
        w_rst_out_nxt  = r_rst_out;
        w_done_nxt     = r_done;

        case (r_state)
            S_IDLE: begin
                w_rst_out_nxt = RST_TYPE;
                w_done_nxt    = 1'b0;
                if (!r_lock_s) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == LOCK_LAST) begin
                    w_state_nxt    = S_HOLD;
                    w_lock_cnt_nxt = '0;
                    w_cnt_nxt      = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_rst_out_nxt[0] = ~RST_TYPE[0];
                    w_cnt_nxt        = '0;
                    w_ch_idx_nxt     = IDX_W'(1);
                    if (CH_NUM == 1) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (r_cnt == STEP_LAST) begin
                    w_rst_out_nxt[r_ch_idx] = ~RST_TYPE[r_ch_idx];
                    w_cnt_nxt               = '0;
                    w_ch_idx_nxt            = r_ch_idx + IDX_W'(1);
                    if (r_ch_idx == LAST_CH) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
        endcase

        // Lock loss outranks a software request; both force every channel back into reset.
        if (r_state != S_IDLE) begin
            if (!r_lock_s) begin
                w_state_nxt    = S_IDLE;
                w_lock_cnt_nxt = '0;
                w_cnt_nxt      = '0;
                w_ch_idx_nxt   = '0;
                w_rst_out_nxt  = RST_TYPE;
                w_done_nxt     = 1'b0;
            end else if (sw_rst_req) begin
                w_state_nxt   = S_HOLD;
                w_cnt_nxt     = '0;
                w_ch_idx_nxt  = '0;
                w_rst_out_nxt = RST_TYPE;
                w_done_nxt    = 1'b0;
            end
        end
    end

    assign rst_out  = r_rst_out;
    assign rst_done = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: three instances (defaults, mixed polarity, single channel)
// share stimulus and are checked against a release-timeline reference model.
module tb_reset_sequencer;

    localparam int LOCK_FILT = 16;
    localparam int HOLD_NUM  = 10;
    localparam int STEP_NUM  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic [3:0] out_a, out_p;
    logic [0:0] out_1;
    logic       done_a, done_p, done_1;
    logic [11:0] w_obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_out(out_a), .rst_done(done_a)
    );

    reset_sequencer #(.RST_TYPE(4'b0101)) dut_pol (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_out(out_p), .rst_done(done_p)
    );

    reset_sequencer #(.CH_NUM(1), .RST_TYPE(1'b1)) dut_one (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst_req(sw_rst_req),
        .rst_out(out_1), .rst_done(done_1)
    );

    assign w_obs = {out_a, done_a, out_p, done_p, out_1[0], done_1};

    // Reference model: lock seen two edges late; m_t counts edges since the sequence (re)started.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_active = 1'b0;
    int   m_streak = 0;
    int   m_t = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_active <= 1'b0; m_streak <= 0; m_t <= 0;
        end else begin
            m_s1 <= locked;
            m_s2 <= m_s1;
            if (!m_active) begin
                if (!m_s2) m_streak <= 0;
                else if (m_streak + 1 == LOCK_FILT) begin
                    m_active <= 1'b1; m_t <= 0; m_streak <= 0;
                end else m_streak <= m_streak + 1;
            end else if (!m_s2) begin
                m_active <= 1'b0; m_streak <= 0;
            end else if (sw_rst_req) begin
                m_t <= 0;
            end else if (m_t < 100000) begin
                m_t <= m_t + 1;
            end
        end
    end

    function automatic int released(int t, int ch, logic act);
        int r = 0;
        if (!act) return 0;
        for (int k = 0; k < ch; k++)
            if (t >= HOLD_NUM + k * STEP_NUM) r++;
        return r;
    endfunction

    function automatic logic [3:0] level(logic [3:0] pol, int rel);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (k < rel) ? ~pol[k] : pol[k];
        return v;
    endfunction

    function automatic logic [11:0] model_all();
        int r4 = released(m_t, 4, m_active);
        int r1 = released(m_t, 1, m_active);
        logic [3:0] a = level(4'hF, r4);
        logic [3:0] p = level(4'b0101, r4);
        logic [3:0] o = level(4'b0001, r1);
        return {a, r4 == 4, p, r4 == 4, o[0], r1 == 1};
    endfunction

    task automatic do_reset(input logic lk);
        @(posedge clk); #1;
        rst_n = 1'b0; locked = 1'b0; sw_rst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; locked = lk;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; locked = 1'b1;
        #1;
        n_vec++;
        if (w_obs !== {4'hF, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL reset_state got %h want %h", w_obs, {4'hF, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0});
        end
        n_vec++;
        if (w_obs !== model_all()) begin
            n_err++; $display("FAIL reset_model got %h want %h", w_obs, model_all());
        end
    endtask

    task automatic test_default();
        do_reset(1'b1);
        for (int e = 1; e <= 45; e++) begin
            int r;
            logic [3:0] dir;
            @(posedge clk); #1;
            r = (e < 28) ? 0 : (e < 32) ? 1 : (e < 36) ? 2 : (e < 40) ? 3 : 4;
            dir = 4'hF << r;
            n_vec++;
            if ({out_a, done_a, done_1} !== {dir, r == 4, r >= 1}) begin
                n_err++; $display("FAIL default_timing e=%0d got %h want %h", e, {out_a, done_a, done_1}, {dir, r == 4, r >= 1});
            end
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL default_model e=%0d got %h want %h", e, w_obs, model_all());
            end
        end
    endtask

    task automatic test_polarity();
        do_reset(1'b1);
        for (int e = 1; e <= 42; e++) begin
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL polarity_model e=%0d got %h want %h", e, w_obs, model_all());
            end
            if (e == 20 || e == 42) begin
                n_vec++;
                if ({out_p, done_p} !== ((e == 20) ? 5'b0101_0 : 5'b1010_1)) begin
                    n_err++; $display("FAIL polarity_level e=%0d got %b want %b", e, {out_p, done_p}, (e == 20) ? 5'b0101_0 : 5'b1010_1);
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(1'b1);
        for (int e = 1; e <= 52; e++) begin
            locked = (e <= 10 || e >= 12);
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL glitch_model e=%0d got %h want %h", e, w_obs, model_all());
            end
            if (e == 38 || e == 39 || e == 51) begin
                n_vec++;
                if ({out_a, done_a} !== ((e == 38) ? 5'h1E : (e == 39) ? 5'h1C : 5'h01)) begin
                    n_err++; $display("FAIL glitch_release e=%0d got %h want %h", e, {out_a, done_a}, (e == 38) ? 5'h1E : (e == 39) ? 5'h1C : 5'h01);
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset(1'b1);
        for (int e = 1; e <= 80; e++) begin
            locked = !(e >= 34 && e < 40);
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL abort_model e=%0d got %h want %h", e, w_obs, model_all());
            end
            if (e == 35 || e == 36 || e == 66 || e == 80) begin
                n_vec++;
                if ({out_a, done_a} !== ((e == 35) ? 5'h18 : (e == 80) ? 5'h01 : 5'h1E)) begin
                    n_err++; $display("FAIL abort_level e=%0d got %h want %h", e, {out_a, done_a}, (e == 35) ? 5'h18 : (e == 80) ? 5'h01 : 5'h1E);
                end
            end
        end
    endtask

    task automatic test_sw_request();
        do_reset(1'b1);
        for (int e = 1; e <= 110; e++) begin
            sw_rst_req = (e == 45 || e == 70 || e == 75);
            locked = (e != 68);
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL sw_model e=%0d got %h want %h", e, w_obs, model_all());
            end
            if (e == 45 || e == 55 || e == 67 || e == 80 || e == 96) begin
                n_vec++;
                if ({out_a, done_a} !== ((e == 55 || e == 96) ? 5'h1C : (e == 67) ? 5'h01 : 5'h1E)) begin
                    n_err++; $display("FAIL sw_level e=%0d got %h want %h", e, {out_a, done_a}, (e == 55 || e == 96) ? 5'h1C : (e == 67) ? 5'h01 : 5'h1E);
                end
            end
        end
        sw_rst_req = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        repeat (33) @(posedge clk);
        #1;
        n_vec++;
        if (out_a !== 4'hC) begin
            n_err++; $display("FAIL async_pre got %h want %h", out_a, 4'hC);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (w_obs !== {4'hF, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL async_reset got %h want %h", w_obs, {4'hF, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        int hold_left = 0;
        do_reset(1'b1);
        for (int e = 1; e <= 2000; e++) begin
            if (hold_left == 0) begin
                locked = ~locked;
                hold_left = locked ? $urandom_range(5, 120) : $urandom_range(1, 20);
            end
            hold_left--;
            sw_rst_req = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
            n_vec++;
            if (w_obs !== model_all()) begin
                n_err++; $display("FAIL random_model e=%0d got %h want %h", e, w_obs, model_all());
            end
        end
        sw_rst_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_polarity();
        test_glitch();
        test_abort();
        test_sw_request();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
